// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status inputs and the stall/flush controls
// returned to the datapath. The pipeline side is the master; the hazard unit is
// the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   IdExMemRead;
    logic [4:0]             IdExrd;
    logic [4:0]             IfIdrs1;
    logic [4:0]             IfIdrs2;
    logic                   branch_taken;
    logic                   imem_miss;
    logic                   imem_ready;
    logic                   dmem_miss;
    logic                   dmem_ready;
    logic                   stall_clr;

    logic                   PcWrite;
    logic                   IfIdWrite;
    logic                   IfIdFlush;
    logic                   IdExBubble;
    logic                   PipeHold;
    logic [1:0]             state;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output IdExMemRead, IdExrd, IfIdrs1, IfIdrs2, branch_taken,
               imem_miss, imem_ready, dmem_miss, dmem_ready, stall_clr,
        input  PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeHold, state, stall_count
    );

    modport slave (
        input  IdExMemRead, IdExrd, IfIdrs1, IfIdrs2, branch_taken,
               imem_miss, imem_ready, dmem_miss, dmem_ready, stall_clr,
        output PcWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeHold, state, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// instruction/data cache miss sequencing, with a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDmiss = 2'd1,
        StImiss = 2'd2,
        StRedir = 2'd3
    } state_e;

    localparam logic [STALL_CNT_W-1:0] CntOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic                   imiss_pend_q, imiss_pend_d;
    logic                   redir_pend_q, redir_pend_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   load_use;
    logic                   pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;

    assign load_use = bus.IdExMemRead && (bus.IdExrd != 5'd0) &&
                      ((bus.IdExrd == bus.IfIdrs1) || (bus.IdExrd == bus.IfIdrs2));

    // Next-state and combinational controls from registered state plus live inputs.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_hold    = 1'b0;
        state_d      = state_q;
        imiss_pend_d = imiss_pend_q;
        redir_pend_d = redir_pend_q;

        unique case (state_q)
            StRun: begin
                // A fill that completed during a data miss after a redirect is stale.
                redir_pend_d = 1'b0;
                if (redir_pend_q) ifid_flush = 1'b1;
                if (bus.dmem_miss) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    state_d    = StDmiss;
                end else if (bus.branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.imem_miss) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = StImiss;
                end
            end
            StDmiss: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
                if (bus.imem_ready) imiss_pend_d = 1'b0;
                if (bus.dmem_ready) begin
                    if (imiss_pend_q && !bus.imem_ready) begin
                        state_d      = redir_pend_q ? StRedir : StImiss;
                        imiss_pend_d = 1'b0;
                        redir_pend_d = 1'b0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StImiss, StRedir: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                if (bus.dmem_miss) begin
                    // Data miss freezes everything; remember the fetch still in flight.
                    ifid_flush   = 1'b0;
                    ifid_write   = 1'b0;
                    pipe_hold    = 1'b1;
                    imiss_pend_d = !bus.imem_ready;
                    redir_pend_d = (state_q == StRedir) && !bus.imem_ready;
                    state_d      = StDmiss;
                end else if (bus.branch_taken) begin
                    pc_write    = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = bus.imem_ready ? StRun : StRedir;
                end else if (bus.imem_ready) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        // Hold defaults while reset is asserted, independent of inputs.
        if (!reset_n) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            pipe_hold   = 1'b0;
        end
    end

    // State, pending flags and saturating stall counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRun;
            imiss_pend_q <= 1'b0;
            redir_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            imiss_pend_q <= imiss_pend_d;
            redir_pend_q <= redir_pend_d;
            if (bus.stall_clr) begin
                stall_cnt_q <= '0;
            end else if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
        end
    end

    assign bus.PcWrite     = pc_write;
    assign bus.IfIdWrite   = ifid_write;
    assign bus.IfIdFlush   = ifid_flush;
    assign bus.IdExBubble  = idex_bubble;
    assign bus.PipeHold    = pipe_hold;
    assign bus.state       = state_q;
    assign bus.stall_count = stall_cnt_q;

endmodule
